// File: rtl/complex_mac_pkg.sv
// Quantum fixed-point package shared by the complex MAC datapath.
// Contents:
//   Q_W, FRAC_BITS      - Q1.18 word geometry (19-bit two's complement)
//   MAX_POS, MIN_LEGAL  - largest / smallest legal Q1.18 codes
//   ILLEGAL_NEG         - the -1.0 code, which is never allowed as an operand
//   cplx_t              - complex amplitude {re, im}
//   mac_state_e         - row-sequencing states of complex_mac
//   q_sanitize()        - maps ILLEGAL_NEG onto MIN_LEGAL
package complex_mac_pkg;

  localparam int unsigned Q_W       = 19;
  localparam int unsigned FRAC_BITS = 18;

  localparam logic [Q_W-1:0] MAX_POS     = 19'h3FFFF;
  localparam logic [Q_W-1:0] MIN_LEGAL   = 19'h40001;
  localparam logic [Q_W-1:0] ILLEGAL_NEG = 19'h40000;

  typedef struct packed {
    logic [Q_W-1:0] re;
    logic [Q_W-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    StAcc,
    StDrain,
    StOut
  } mac_state_e;

  function automatic logic [Q_W-1:0] q_sanitize(input logic [Q_W-1:0] v);
    return (v == ILLEGAL_NEG) ? MIN_LEGAL : v;
  endfunction

endpackage

// File: rtl/cplx_prod.sv
// Complex product g * s for one MAC beat.
// Ports:
//   i_g, i_s   - complex Q1.18 operands (gate element, state amplitude)
//   o_term_re  - rr - ii, one guard bit wider than Q1.18
//   o_term_im  - ri + ir, one guard bit wider than Q1.18
// Operands equal to -1.0 are replaced by the smallest legal code, and any
// partial product with a zero operand is forced to zero so the multiplier's
// negative-times-zero behaviour can never leak into the sum.
module cplx_prod
  import complex_mac_pkg::*;
(
  input  cplx_t        i_g,
  input  cplx_t        i_s,
  output logic [Q_W:0] o_term_re,
  output logic [Q_W:0] o_term_im
);

  cplx_t w_g;
  cplx_t w_s;

  logic [Q_W-1:0] w_rr_raw, w_ii_raw, w_ri_raw, w_ir_raw;
  logic [Q_W-1:0] w_rr, w_ii, w_ri, w_ir;

  assign w_g.re = q_sanitize(i_g.re);
  assign w_g.im = q_sanitize(i_g.im);
  assign w_s.re = q_sanitize(i_s.re);
  assign w_s.im = q_sanitize(i_s.im);

  q18_mult u_mul_rr (.i_a(w_g.re), .i_b(w_s.re), .o_p(w_rr_raw));
  q18_mult u_mul_ii (.i_a(w_g.im), .i_b(w_s.im), .o_p(w_ii_raw));
  q18_mult u_mul_ri (.i_a(w_g.re), .i_b(w_s.im), .o_p(w_ri_raw));
  q18_mult u_mul_ir (.i_a(w_g.im), .i_b(w_s.re), .o_p(w_ir_raw));

  assign w_rr = (w_g.re == '0 || w_s.re == '0) ? '0 : w_rr_raw;
  assign w_ii = (w_g.im == '0 || w_s.im == '0) ? '0 : w_ii_raw;
  assign w_ri = (w_g.re == '0 || w_s.im == '0) ? '0 : w_ri_raw;
  assign w_ir = (w_g.im == '0 || w_s.re == '0) ? '0 : w_ir_raw;

  assign o_term_re = {w_rr[Q_W-1], w_rr} - {w_ii[Q_W-1], w_ii};
  assign o_term_im = {w_ri[Q_W-1], w_ri} + {w_ir[Q_W-1], w_ir};

endmodule

// File: rtl/q18_mult.sv
// 19-bit Q1.18 fixed-point multiplier.
// Ports:
//   i_a, i_b - Q1.18 operands
//   o_p      - Q1.18 product, full product arithmetically shifted down by FRAC_BITS
//              (truncation toward minus infinity) and cut to Q_W bits
module q18_mult
  import complex_mac_pkg::*;
(
  input  logic [Q_W-1:0] i_a,
  input  logic [Q_W-1:0] i_b,
  output logic [Q_W-1:0] o_p
);

  logic signed [2*Q_W-1:0] w_prod;

  assign w_prod = $signed(i_a) * $signed(i_b);
  assign o_p    = Q_W'(w_prod >>> FRAC_BITS);

endmodule

// File: rtl/complex_mac.sv
// Streaming complex multiply-accumulate over one gate-matrix row.
// Ports:
//   i_clk, i_reset_n          - clock, asynchronous active-low reset
//   i_in_valid / o_in_ready   - beat handshake; i_in_last marks the final beat
//   i_g_re, i_g_im            - gate element, Q1.18
//   i_s_re, i_s_im            - state amplitude, Q1.18
//   o_out_valid / i_out_ready - result handshake; result held until taken
//   o_out_re, o_out_im        - saturated row sum, Q1.18
//   o_out_sat                 - either component clamped
//   o_out_err                 - in_last position disagreed with N_TERMS
// Flow: each accepted beat registers its product term; the term is folded
// into the accumulators on the following edge. The row-ending beat moves to
// DRAIN, which folds in the final term, saturates and presents the result.
module complex_mac
  import complex_mac_pkg::*;
#(
  parameter int unsigned N_TERMS = 2,
  parameter int unsigned ACC_W   = 22
) (
  input  logic           i_clk,
  input  logic           i_reset_n,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic           i_in_last,
  input  logic [Q_W-1:0] i_g_re,
  input  logic [Q_W-1:0] i_g_im,
  input  logic [Q_W-1:0] i_s_re,
  input  logic [Q_W-1:0] i_s_im,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [Q_W-1:0] o_out_re,
  output logic [Q_W-1:0] o_out_im,
  output logic           o_out_sat,
  output logic           o_out_err
);

  localparam int unsigned TERM_W = Q_W + 1;
  localparam int unsigned CNT_W  = $clog2(N_TERMS + 1);

  localparam logic [CNT_W-1:0]        LAST_IDX = CNT_W'(N_TERMS - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((1 << FRAC_BITS) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO   = -SAT_HI;

  // Returns {clamped, value}.
  function automatic logic [Q_W:0] sat_q(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI) begin
      return {1'b1, MAX_POS};
    end else if (v < SAT_LO) begin
      return {1'b1, MIN_LEGAL};
    end
    return {1'b0, v[Q_W-1:0]};
  endfunction

  cplx_t                     w_g, w_s;
  logic [TERM_W-1:0]         w_prod_re, w_prod_im;
  logic signed [ACC_W-1:0]   w_term_re, w_term_im;
  logic signed [ACC_W-1:0]   w_sum_re, w_sum_im;
  logic [Q_W:0]              w_sat_re, w_sat_im;
  logic                      w_accept, w_row_end, w_cnt_last;
  mac_state_e                w_state_d;

  mac_state_e                r_state;
  logic signed [ACC_W-1:0]   r_acc_re, r_acc_im;
  logic signed [ACC_W-1:0]   r_term_re, r_term_im;
  logic                      r_term_vld;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_err_pend;
  logic [Q_W-1:0]            r_out_re, r_out_im;
  logic                      r_out_valid, r_out_sat, r_out_err;

  assign w_g.re = i_g_re;
  assign w_g.im = i_g_im;
  assign w_s.re = i_s_re;
  assign w_s.im = i_s_im;

  cplx_prod u_prod (
    .i_g       (w_g),
    .i_s       (w_s),
    .o_term_re (w_prod_re),
    .o_term_im (w_prod_im)
  );

  assign w_term_re = ACC_W'($signed(w_prod_re));
  assign w_term_im = ACC_W'($signed(w_prod_im));

  assign w_sum_re = r_acc_re + (r_term_vld ? r_term_re : '0);
  assign w_sum_im = r_acc_im + (r_term_vld ? r_term_im : '0);
  assign w_sat_re = sat_q(w_sum_re);
  assign w_sat_im = sat_q(w_sum_im);

  assign o_in_ready = (r_state == StAcc);
  assign w_accept   = i_in_valid && o_in_ready;
  assign w_cnt_last = (r_cnt == LAST_IDX);
  assign w_row_end  = w_accept && (i_in_last || w_cnt_last);

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StAcc:   if (w_row_end) w_state_d = StDrain;
      StDrain: w_state_d = StOut;
      StOut:   if (i_out_ready) w_state_d = StAcc;
      default: w_state_d = StAcc;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= StAcc;
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_term_re   <= '0;
      r_term_im   <= '0;
      r_term_vld  <= 1'b0;
      r_cnt       <= '0;
      r_err_pend  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_valid <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      unique case (r_state)
        StAcc: begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
          if (w_accept) begin
            r_term_re  <= w_term_re;
            r_term_im  <= w_term_im;
            r_term_vld <= 1'b1;
            r_cnt      <= r_cnt + CNT_W'(1);
            // Framing is wrong when exactly one of "last flag" and
            // "final counted beat" holds on the closing beat.
            if (w_row_end) r_err_pend <= i_in_last != w_cnt_last;
          end else begin
            r_term_vld <= 1'b0;
          end
        end
        StDrain: begin
          r_acc_re    <= w_sum_re;
          r_acc_im    <= w_sum_im;
          r_term_vld  <= 1'b0;
          r_out_re    <= w_sat_re[Q_W-1:0];
          r_out_im    <= w_sat_im[Q_W-1:0];
          r_out_sat   <= w_sat_re[Q_W] | w_sat_im[Q_W];
          r_out_err   <= r_err_pend;
          r_out_valid <= 1'b1;
        end
        StOut: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_acc_re    <= '0;
            r_acc_im    <= '0;
            r_cnt       <= '0;
            r_err_pend  <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_re    = r_out_re;
  assign o_out_im    = r_out_im;
  assign o_out_sat   = r_out_sat;
  assign o_out_err   = r_out_err;

endmodule
